// File: rtl/mult_seq_ctrl_if.sv
// Handshake and multiplier-array bundle for mult_seq_ctrl.
// The slave modport is the sequencer side; the master side drives jobs and operands and supplies products.
interface mult_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_NUM  = 6,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 10
) ();
  logic                              start;
  logic [LEN_WIDTH-1:0]              vec_len;
  logic                              busy;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*INPUT_NUM-1:0]   in_data;
  logic [DATA_WIDTH*INPUT_NUM-1:0]   in_weight;
  logic [DATA_WIDTH*INPUT_NUM-1:0]   mult_a;
  logic [DATA_WIDTH*INPUT_NUM-1:0]   mult_b;
  logic [2*DATA_WIDTH*INPUT_NUM-1:0] mult_p;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACC_WIDTH-1:0]              out_data;

  modport slave (
    input  start, vec_len, in_valid, in_data, in_weight, mult_p, out_ready,
    output busy, in_ready, mult_a, mult_b, out_valid, out_data
  );

  modport master (
    output start, vec_len, in_valid, in_data, in_weight, mult_p, out_ready,
    input  busy, in_ready, mult_a, mult_b, out_valid, out_data
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Dot-product sequencer for an external combinational multiplier array:
// registers operands, reduces lane products per beat and accumulates one result per job.
module mult_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_NUM  = 6,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_seq_ctrl_if.slave   bus
);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int PSUM_W = 2*DATA_WIDTH + $clog2(INPUT_NUM);
  localparam int LANE_W = DATA_WIDTH*INPUT_NUM;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [LANE_W-1:0]       opa_p1, opb_p1;
  logic                    vld_p1, vld_p2;
  logic [PSUM_W-1:0]       psum_p2;
  logic [ACC_WIDTH-1:0]    acc_p3;
  logic                    accept;
  logic                    busy, in_ready, out_valid;

  function automatic logic [PSUM_W-1:0] lane_sum(input logic [PROD_W*INPUT_NUM-1:0] p);
    logic [PSUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < INPUT_NUM; i++)
      s = s + PSUM_W'(p[PROD_W*i +: PROD_W]);
    return s;
  endfunction

  // Modular accumulate: overflow wraps silently.
  function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [PSUM_W-1:0]    b);
    return a + ACC_WIDTH'(b);
  endfunction

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = (bus.vec_len != '0) ? RUN : DONE;
      end
      RUN: begin
        in_ready = (remaining != '0);
        if (accept && remaining == LEN_WIDTH'(1))
          state_nxt = DRAIN;
      end
      // The last beat sits in stage 1 for one cycle; once it moves on, the final add lands this edge.
      DRAIN: begin
        if (!vld_p1)
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      opa_p1    <= '0;
      opb_p1    <= '0;
      vld_p1    <= 1'b0;
      psum_p2   <= '0;
      vld_p2    <= 1'b0;
      acc_p3    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start)
        remaining <= bus.vec_len;
      else if (accept)
        remaining <= remaining - LEN_WIDTH'(1);
      // S1: operand registers feed the multiplier array
      vld_p1 <= accept;
      if (accept) begin
        opa_p1 <= bus.in_data;
        opb_p1 <= bus.in_weight;
      end
      // S2: reduce lane products of the beat launched last cycle
      vld_p2 <= vld_p1;
      if (vld_p1)
        psum_p2 <= lane_sum(bus.mult_p);
      // S3: accumulate; a new job clears the accumulator
      if (state == IDLE && bus.start)
        acc_p3 <= '0;
      else if (vld_p2)
        acc_p3 <= wrap_add(acc_p3, psum_p2);
    end
  end

  assign bus.busy      = busy;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = acc_p3;
  assign bus.mult_a    = opa_p1;
  assign bus.mult_b    = opb_p1;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural multiplier array on the product bus.
module tb_mult_seq_ctrl;
  localparam int DW = 16;
  localparam int N  = 6;
  localparam int AW = 40;
  localparam int LW = 10;
  localparam int LANES = DW*N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   accepts = 0;
  int   ready_cycles = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.DATA_WIDTH(DW), .INPUT_NUM(N), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  mult_seq_ctrl #(.DATA_WIDTH(DW), .INPUT_NUM(N), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    bus.mult_p = '0;
    for (int i = 0; i < N; i++)
      bus.mult_p[2*DW*i +: 2*DW] = 32'(bus.mult_a[DW*i +: DW]) * 32'(bus.mult_b[DW*i +: DW]);
  end

  always @(posedge clk) if (bus.in_valid && bus.in_ready) accepts++;
  always @(negedge clk) if (bus.in_ready) ready_cycles++;

  function automatic logic [LANES-1:0] fill(input logic [DW-1:0] v);
    logic [LANES-1:0] r;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES-1:0] seq_lanes();
    logic [LANES-1:0] r;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = DW'(i + 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    bus.vec_len = LW'(len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Holds one beat until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [LANES-1:0] d, input logic [LANES-1:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_weight = w;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL beat_accept: in_ready never rose within %0d cycles", n);
    end else begin
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL %s_timeout: out_valid=%0b after %0d cycles, required 1", name, bus.out_valid, n);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.vec_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL rst_out_data: got %0d want 0", bus.out_data); else passed++;
    total++; if (bus.mult_a !== '0) $display("FAIL rst_mult_a: got %h want 0", bus.mult_a); else passed++;
    total++; if (bus.mult_b !== '0) $display("FAIL rst_mult_b: got %h want 0", bus.mult_b); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    bus.out_ready = 1'b1;
    start_job(1);
    send_beat(fill(16'd1), fill(16'd2));
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t1_valid_e0: got %0b want 0", bus.out_valid); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t1_valid_e1: got %0b want 0", bus.out_valid); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL t1_valid_e2: got %0b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 40'd12) $display("FAIL t1_data: got %0d want 12", bus.out_data); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t1_pulse: got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL t1_idle: busy got %0b want 0", bus.busy); else passed++;
  endtask

  task automatic test_bubbles();
    int base;
    bus.out_ready = 1'b1;
    start_job(3);
    base = accepts;
    for (int b = 0; b < 3; b++) begin
      send_beat(seq_lanes(), fill(16'd1));
      if (b < 2) begin
        tick();
        tick();
      end
    end
    total++; if (bus.in_ready !== 1'b0) $display("FAIL t2_ready_after_last: got %0b want 0", bus.in_ready); else passed++;
    wait_out_valid("t2");
    total++; if (bus.out_data !== 40'd63) $display("FAIL t2_data: got %0d want 63", bus.out_data); else passed++;
    total++; if (accepts - base !== 3) $display("FAIL t2_accepts: got %0d want 3", accepts - base); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    start_job(2);
    send_beat(seq_lanes(), fill(16'd2));
    send_beat(seq_lanes(), fill(16'd2));
    wait_out_valid("t3");
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.out_valid !== 1'b1) $display("FAIL t3_hold_valid[%0d]: got %0b want 1", c, bus.out_valid); else passed++;
      total++; if (bus.out_data !== 40'd84) $display("FAIL t3_hold_data[%0d]: got %0d want 84", c, bus.out_data); else passed++;
      if (c == 2) begin
        bus.vec_len = LW'(5);
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t3_release: out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL t3_idle: busy got %0b want 0", bus.busy); else passed++;
  endtask

  task automatic test_zero_len();
    int base;
    bus.out_ready = 1'b0;
    base = ready_cycles;
    start_job(0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL t4_valid: got %0b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 40'd0) $display("FAIL t4_data: got %0d want 0", bus.out_data); else passed++;
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL t4_idle: busy got %0b want 0", bus.busy); else passed++;
    total++; if (ready_cycles - base !== 0) $display("FAIL t4_in_ready: high %0d cycles, want 0", ready_cycles - base); else passed++;
  endtask

  task automatic test_wrap();
    int base;
    int n;
    bus.out_ready = 1'b1;
    start_job(64);
    base = accepts;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = fill(16'hFFFF);
    bus.in_weight = fill(16'hFFFF);
    while (accepts - base < 64 && n < 300) begin
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    total++; if (accepts - base !== 64) $display("FAIL t5_accepts: got %0d want 64", accepts - base); else passed++;
    wait_out_valid("t5");
    total++; if (bus.out_data !== 40'd549705482624) $display("FAIL t5_wrap: got %0d want 549705482624", bus.out_data); else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    bus.out_ready = 1'b1;
    start_job(4);
    send_beat(fill(16'd1), fill(16'd1));
    send_beat(fill(16'd1), fill(16'd1));
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL t6_busy: got %0b want 0", bus.busy); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL t6_in_ready: got %0b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t6_out_valid: got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL t6_out_data: got %0d want 0", bus.out_data); else passed++;
    total++; if (bus.mult_a !== '0) $display("FAIL t6_mult_a: got %h want 0", bus.mult_a); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL t6_no_result: got %0b want 0", bus.out_valid); else passed++;
    start_job(1);
    send_beat(fill(16'd3), fill(16'd3));
    wait_out_valid("t6");
    total++; if (bus.out_data !== 40'd54) $display("FAIL t6_fresh_job: got %0d want 54", bus.out_data); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_bubbles();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
